// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM states, owner codes
// and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic [1:0] owner_of(input logic [1:0] grant);
    if (grant[1])      return OWNER_P1;
    else if (grant[0]) return OWNER_P0;
    else               return OWNER_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int M = 16,
  parameter int N = 32
);
  logic [N-1:0] addr0, addr1;
  logic [M-1:0] wdata0, wdata1;
  logic         re0, re1, we0, we1;
  logic         lock1;
  logic [M-1:0] rdata0, rdata1;
  logic         ready0, ready1;
  logic [N-1:0] memAddr;
  logic [M-1:0] memWrite;
  logic         memRE, memWE;
  logic [M-1:0] memRead;
  logic         memReady;

  modport slave (
    input  addr0, addr1, wdata0, wdata1, re0, re1, we0, we1, lock1,
    input  memRead, memReady,
    output rdata0, rdata1, ready0, ready1,
    output memAddr, memWrite, memRE, memWE
  );

  modport master (
    output addr0, addr1, wdata0, wdata1, re0, re1, we0, we1, lock1,
    output memRead, memReady,
    input  rdata0, rdata1, ready0, ready1,
    input  memAddr, memWrite, memRE, memWE
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector used while the arbiter is idle.
// A locked port 1 that won last time keeps winning while it keeps requesting.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (lock && (last == PORT1) && req[1]) begin
      grant = 2'b10;
    end else if (req == 2'b11) begin
      grant = (last == PORT1) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: zero-latency combinational grant and mux, an
// IDLE/HOLD0/HOLD1 FSM that holds a grant until completion, and a watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int M       = 16,
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output logic                timeoutErr,
  output logic [1:0]          owner
);

  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires in the HOLD cycle whose increment would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST  = CW'(TMO_EN ? TIMEOUT - 1 : 0);
  localparam logic [M-1:0]  ZERO_DATA = '0;
  localparam logic [N-1:0]  ZERO_ADDR = '0;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  logic [1:0] pick;
  logic [1:0] grant;
  logic       gport;
  logic       gnt_req;
  logic       timeout_hit;

  assign req = {bus.re1 | bus.we1, bus.re0 | bus.we0};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .lock  (bus.lock1),
    .grant (pick)
  );

  // Gating with rst keeps every output at zero while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst) begin
      case (state_q)
        ST_HOLD0: grant = 2'b01;
        ST_HOLD1: grant = 2'b10;
        default:  grant = pick;
      endcase
    end
  end

  assign gport   = grant[1];
  assign gnt_req = |(grant & req);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (grant == 2'b00 || !gnt_req) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bus.memReady) begin
      state_d = ST_IDLE;
      last_d  = gport;
      cnt_d   = '0;
    end else if (state_q != ST_IDLE) begin
      if (TMO_EN && cnt_q == CNT_LAST) begin
        state_d     = ST_IDLE;
        last_d      = gport;
        cnt_d       = '0;
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      state_d = gport ? ST_HOLD1 : ST_HOLD0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= PORT1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.memAddr  = ZERO_ADDR;
    bus.memWrite = ZERO_DATA;
    bus.memRE    = 1'b0;
    bus.memWE    = 1'b0;
    if (grant[0]) begin
      bus.memAddr  = bus.addr0;
      bus.memWrite = bus.wdata0;
      bus.memWE    = bus.we0;
      bus.memRE    = bus.re0 & ~bus.we0;
    end else if (grant[1]) begin
      bus.memAddr  = bus.addr1;
      bus.memWrite = bus.wdata1;
      bus.memWE    = bus.we1;
      bus.memRE    = bus.re1 & ~bus.we1;
    end
  end

  assign bus.ready0 = grant[0] & bus.memReady;
  assign bus.ready1 = grant[1] & bus.memReady;
  assign bus.rdata0 = grant[0] ? bus.memRead : ZERO_DATA;
  assign bus.rdata1 = grant[1] ? bus.memRead : ZERO_DATA;
  assign timeoutErr = timeout_hit;
  assign owner      = owner_of(grant);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): single access, contention,
// wait states, locked burst, watchdog abort and asynchronous reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timeoutErr;
  logic [1:0] owner;
  int         vectors = 0;
  int         miscompares = 0;

  mem_arbiter_if #(.M(16), .N(32)) bus ();

  mem_arbiter #(.M(16), .N(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .timeoutErr (timeoutErr),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // {owner, ready1, ready0, memRE, memWE, timeoutErr}
  wire [6:0] ctl = {owner, bus.ready1, bus.ready0, bus.memRE, bus.memWE, timeoutErr};

  task automatic clear_inputs();
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.re0 = 0; bus.re1 = 0; bus.we0 = 0; bus.we1 = 0; bus.lock1 = 0;
    bus.memRead = '0; bus.memReady = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.re0 = 1; bus.we1 = 1; bus.addr0 = 32'h10; bus.addr1 = 32'h14;
    bus.memReady = 1; bus.memRead = 16'hFFFF;
    #2;
    vectors++;
    if (ctl !== 7'b00_0_0_0_0_0) begin
      miscompares++; $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0);
    end
    vectors++;
    if ({bus.memAddr, bus.rdata0, bus.rdata1} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus addr=%h rd0=%h rd1=%h want 0", bus.memAddr, bus.rdata0, bus.rdata1);
    end
    $display("reset: ctl=%b memAddr=%h", ctl, bus.memAddr);
    clear_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    bus.re0 = 1; bus.addr0 = 32'h10; bus.memReady = 1; bus.memRead = 16'h1234;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b01_0_1_1_0_0) begin
      miscompares++; $display("FAIL single_ctl got=%b want=%b", ctl, 7'b01_0_1_1_0_0);
    end
    vectors++;
    if ({bus.memAddr, bus.rdata0, bus.rdata1} !== {32'h10, 16'h1234, 16'h0}) begin
      miscompares++;
      $display("FAIL single_data addr=%h rd0=%h rd1=%h want 10/1234/0", bus.memAddr, bus.rdata0, bus.rdata1);
    end
    $display("single read: ctl=%b addr=%h rdata0=%h", ctl, bus.memAddr, bus.rdata0);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [6:0] exp_ctl [3];
    logic [31:0] exp_addr [3];
    exp_ctl[0] = 7'b01_0_1_1_0_0; exp_addr[0] = 32'h20;
    exp_ctl[1] = 7'b10_1_0_0_1_0; exp_addr[1] = 32'h30;
    exp_ctl[2] = 7'b01_0_1_1_0_0; exp_addr[2] = 32'h20;
    do_reset();
    bus.re0 = 1; bus.addr0 = 32'h20;
    bus.we1 = 1; bus.addr1 = 32'h30; bus.wdata1 = 16'hBEEF;
    bus.memReady = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== exp_ctl[i] || bus.memAddr !== exp_addr[i]) begin
        miscompares++;
        $display("FAIL contention_c%0d ctl=%b addr=%h want ctl=%b addr=%h", i, ctl, bus.memAddr, exp_ctl[i], exp_addr[i]);
      end
      if (i == 1) begin
        vectors++;
        if (bus.memWrite !== 16'hBEEF) begin
          miscompares++; $display("FAIL contention_wdata got=%h want=beef", bus.memWrite);
        end
      end
      $display("contention c%0d: ctl=%b addr=%h", i, ctl, bus.memAddr);
      next_cycle();
    end
    clear_inputs();
  endtask

  // Runs straight after contention, so last=0 and port 1 wins the tie.
  task automatic test_wait_states();
    bus.re0 = 1; bus.addr0 = 32'h40; bus.re1 = 1; bus.addr1 = 32'h50;
    bus.memRead = 16'hA5A5; bus.memReady = 0;
    for (int i = 1; i <= 5; i++) begin
      logic [6:0] exp;
      bus.memReady = (i >= 4);
      exp = (i <= 3) ? 7'b10_0_0_1_0_0 : (i == 4) ? 7'b10_1_0_1_0_0 : 7'b01_0_1_1_0_0;
      @(negedge clk);
      vectors++;
      if (ctl !== exp) begin
        miscompares++; $display("FAIL wait_c%0d ctl=%b want=%b", i, ctl, exp);
      end
      if (i == 4) begin
        vectors++;
        if (bus.rdata1 !== 16'hA5A5 || bus.rdata0 !== 16'h0 || bus.memAddr !== 32'h50) begin
          miscompares++;
          $display("FAIL wait_rdata rd1=%h rd0=%h addr=%h want a5a5/0/50", bus.rdata1, bus.rdata0, bus.memAddr);
        end
      end
      $display("wait c%0d: ctl=%b addr=%h", i, ctl, bus.memAddr);
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lock_burst();
    do_reset();
    bus.re0 = 1; bus.addr0 = 32'h60;
    bus.we1 = 1; bus.lock1 = 1; bus.memReady = 1;
    for (int i = 0; i < 4; i++) begin
      bus.addr1 = 32'h100 + 32'(i);
      bus.wdata1 = 16'h1000 + 16'(i);
      @(negedge clk);
      vectors++;
      if (ctl !== 7'b10_1_0_0_1_0 || bus.memAddr !== 32'h100 + 32'(i) ||
          bus.memWrite !== 16'h1000 + 16'(i)) begin
        miscompares++;
        $display("FAIL lock_w%0d ctl=%b addr=%h wd=%h want ctl=1010010", i, ctl, bus.memAddr, bus.memWrite);
      end
      $display("lock burst w%0d: ctl=%b addr=%h wdata=%h", i, ctl, bus.memAddr, bus.memWrite);
      next_cycle();
    end
    bus.lock1 = 0;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b01_0_1_1_0_0 || bus.memAddr !== 32'h60) begin
      miscompares++; $display("FAIL lock_release ctl=%b addr=%h want 0101100/60", ctl, bus.memAddr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b10_1_0_0_1_0) begin
      miscompares++; $display("FAIL lock_after ctl=%b want=1010010", ctl);
    end
    $display("lock release: ctl=%b", ctl);
    next_cycle();
    clear_inputs();
  endtask

  // Cycle 0 is the IDLE grant; HOLD0 cycles are 1..4, abort on the 4th.
  task automatic test_timeout();
    do_reset();
    bus.re0 = 1; bus.addr0 = 32'h70; bus.re1 = 1; bus.addr1 = 32'h74;
    for (int i = 0; i <= 4; i++) begin
      logic [6:0] exp;
      exp = (i == 4) ? 7'b01_0_0_1_0_1 : 7'b01_0_0_1_0_0;
      @(negedge clk);
      vectors++;
      if (ctl !== exp) begin
        miscompares++; $display("FAIL timeout_c%0d ctl=%b want=%b", i, ctl, exp);
      end
      $display("timeout c%0d: ctl=%b", i, ctl);
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b10_0_0_1_0_0 || bus.memAddr !== 32'h74) begin
      miscompares++; $display("FAIL timeout_next ctl=%b addr=%h want 1000100/74", ctl, bus.memAddr);
    end
    $display("after timeout: ctl=%b addr=%h", ctl, bus.memAddr);

    do_reset();
    bus.re0 = 1; bus.addr0 = 32'h78;
    repeat (4) next_cycle();
    bus.memReady = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b01_0_1_1_0_0) begin
      miscompares++; $display("FAIL timeout_vs_ready ctl=%b want=0101100", ctl);
    end
    $display("ready at expiry: ctl=%b", ctl);
    next_cycle();
    bus.memReady = 0;
    repeat (3) next_cycle();
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b01_0_0_1_0_0) begin
      miscompares++; $display("FAIL timeout_restart ctl=%b want=0100100", ctl);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.re1 = 1; bus.addr1 = 32'h80; bus.memRead = 16'h5A5A;
    @(negedge clk);
    vectors++;
    if (owner !== OWNER_P1) begin
      miscompares++; $display("FAIL midrst_grant owner=%b want=10", owner);
    end
    next_cycle();
    bus.re0 = 1; bus.addr0 = 32'h84;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b10_0_0_1_0_0) begin
      miscompares++; $display("FAIL midrst_hold ctl=%b want=1000100", ctl);
    end
    @(posedge clk);
    #3;
    bus.memReady = 1;
    rst = 1'b0;
    #1;
    vectors++;
    if (ctl !== 7'b0 || bus.memAddr !== 32'h0 || bus.rdata1 !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_async ctl=%b addr=%h rd1=%h want all 0", ctl, bus.memAddr, bus.rdata1);
    end
    $display("reset mid HOLD1: ctl=%b addr=%h", ctl, bus.memAddr);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b01_0_1_1_0_0 || bus.memAddr !== 32'h84) begin
      miscompares++; $display("FAIL midrst_tie ctl=%b addr=%h want 0101100/84", ctl, bus.memAddr);
    end
    $display("after release: ctl=%b addr=%h", ctl, bus.memAddr);
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_lock_burst();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the RCPU memory port (port 0) and a second bus master such as DMA, debug loader or video fetch (port 1), driving a single shared memory interface. It multiplexes address, write data and read/write enables, returns `ready` only to the granted master, and keeps a grant until that master's access completes. It uses round-robin fairness and detects downstream accesses that hang.

## Interface
Parameters:
- `M`, 16, data bus width
- `N`, 32, address bus width
- `TIMEOUT`, 255, max cycles a granted access may wait for `memReady` before aborting; 0 disables

Ports:
- `clk`  input  1  clock, rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `addr0`/`addr1`  input  N  master address
- `wdata0`/`wdata1`  input  M  master write data
- `re0`/`re1`, `we0`/`we1`  input  1  master read/write enables; `re`&`we` together is illegal, and `we` wins
- `lock1`  input  1  port 1 keeps its grant across consecutive accesses (burst)
- `rdata0`/`rdata1`  output  M  read data, equal to `memRead` while that port is granted, else 0
- `ready0`/`ready1`  output  1  access completes this cycle
- `memAddr`  output  N, `memWrite`  output  M, `memRE`/`memWE`  output  1  shared memory side
- `memRead`  input  M, `memReady`  input  1  shared memory side
- `timeoutErr`  output  1  one-cycle pulse when an access is aborted
- `owner`  output  2  debug: 00 none, 01 port 0, 10 port 1

## Operation
- A request is `reN | weN`. An access completes in a cycle where the granted port requests and `memReady`=1.
- States: IDLE, HOLD0, HOLD1. HOLDx means port x was granted and its access has not completed yet.
- Grant selection (combinational):
  - In HOLDx, port x is granted.
  - In IDLE, a single requester is granted.
  - In IDLE with both requesting, grant the port not equal to `last`.
  - In IDLE, if `lock1` is active and `last`=1, port 1 is granted whenever it requests.
- Memory side mirrors the granted port: `memAddr`, `memWrite`, `memRE`, `memWE`. With no grant, all are 0.
- `readyX = grantX & memReady`. The ungranted port sees `ready`=0. The CPU therefore stalls through its own `!ready & re` logic with no change to the CPU.
- Transitions on each clock edge:
  - Granted access completes: go to IDLE and set `last` to the granted port.
  - Granted but not complete: go to or stay in HOLDx.
  - Granted port drops its request while in HOLDx: go to IDLE and leave `last` unchanged. This is an abandoned access and is legal.
- Timeout counter:
  - Clears on entry to HOLDx and in IDLE.
  - Increments each HOLDx cycle.
  - On reaching `TIMEOUT`, go to IDLE, pulse `timeoutErr`, and set `last` to the stalled port so the other port gets the next grant. The master is not given `ready`.
- Counter width is ceil(log2(TIMEOUT+1)). Saturation is not needed because the counter is forced to IDLE at `TIMEOUT`.

## Timing
- Zero added latency: grant, mux and `ready` are combinational in the same cycle as the request. An uncontended access costs exactly the memory's own latency.
- Contention: the loser waits for the winner's completion cycle and is granted on the following cycle. Worst-case wait for port 0 without `lock1` is one port-1 access.
- A master keeping its request asserted after `ready` starts a new access. It is re-arbitrated the next cycle, so back-to-back CPU fetches alternate with a waiting port 1.
- Reset (`rst`=0, asynchronous):
  - State IDLE, `last`=1 (port 0 wins the first tie), counter 0.
  - `timeoutErr`=0, `owner`=00.
  - All memory-side outputs, `ready*` and `rdata*` are 0 through combinational decode.
- Reset asserted mid-access aborts it immediately with no `ready`.
- `memReady` arriving in the same cycle the timeout expires: completion wins and no error is raised.

## Structure
- Shared package/constants file: state encodings (IDLE, HOLD0, HOLD1), the `owner` encodings, and the port index constants.
- One natural sub-module, `rr_pick2`: combinational two-way round-robin selector, inputs `req[1:0]`, `last`, `lock`; output one-hot `grant`.
- The rest (FSM register, timeout counter, output muxes) is in `mem_arbiter`.

## Test plan
- Port 0 reads `0x00000010` alone with `memReady`=1 → `memAddr`=`0x10`, `memRE`=1, `ready0`=1 the same cycle, `rdata0`=`memRead`, `ready1`=0.
- Both request after reset (`re0` addr `0x20`, `we1` addr `0x30` wdata `0xBEEF`), `memReady`=1 → cycle 0 grants port 0, cycle 1 grants port 1 with `memWE`=1 and `memWrite`=`0xBEEF`, cycle 2 grants port 0.
- Port 1 granted, `memReady`=0 for 3 cycles then 1, port 0 also requesting → state HOLD1 for 3 cycles, `ready0`=0 throughout, `ready1`=1 on the 4th cycle, port 0 granted on the 5th.
- `lock1`=1 with port 1 doing 4 back-to-back writes while port 0 requests → 4 consecutive `ready1` pulses, then port 0 is granted once `lock1` drops.
- `TIMEOUT`=4, port 0 granted, `memReady` held 0 → `timeoutErr` pulses on the 4th cycle, state IDLE, and port 1 is granted next if requesting.
- `rst` pulled low during HOLD1 → outputs go to 0 asynchronously, `owner`=00, and port 0 wins the first tie after release.
